// File: rtl/fan_duty_ctrl_pkg.sv
// Shared definitions for the fan duty controller and the PWM stage it feeds.
// Holds state encodings, duty width/full-scale and the slew helper.
package fan_ctrl_pkg;

    localparam int              DUTY_W    = 12;
    localparam logic [DUTY_W-1:0] DUTY_FULL = 12'hFFF;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_KICK  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FORCE = 2'd3
    } fan_state_e;

    // One slew step toward tgt; one extra bit so neither 0 nor FFF can wrap.
    function automatic logic [DUTY_W-1:0] slew_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt,
                                                      input logic [DUTY_W-1:0] step);
        logic [DUTY_W:0] c, t, s;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        s = {1'b0, step};
        if (c > t)
            return ((c - t) > s) ? DUTY_W'(c - s) : tgt;
        else
            return ((t - c) > s) ? DUTY_W'(c + s) : tgt;
    endfunction

endpackage

// File: rtl/fan_duty_ctrl_if.sv
// Sample/override inputs and duty/status outputs of the fan duty controller.
interface fan_duty_ctrl_if;
    logic [11:0]               temp_in;
    logic                      temp_valid_in;
    logic                      force_full_in;
    logic [11:0]               duty_out;
    fan_ctrl_pkg::fan_state_e  state_out;
    logic                      at_target_out;

    modport master (
        output temp_in, temp_valid_in, force_full_in,
        input  duty_out, state_out, at_target_out
    );

    modport slave (
        input  temp_in, temp_valid_in, force_full_in,
        output duty_out, state_out, at_target_out
    );
endinterface

// File: rtl/fan_duty_ctrl_tick_gen.sv
// Free-running prescaler; tick_o is high for one cycle at the terminal count.
module tick_gen #(
    parameter logic [15:0] TICK_DIV = 16'd50000
) (
    input  logic clk_in,
    input  logic rst_n_in,
    output logic tick_o
);
    logic [15:0] cnt_q;

    assign tick_o = (cnt_q == TICK_DIV - 16'd1);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) cnt_q <= '0;
        else           cnt_q <= tick_o ? 16'd0 : cnt_q + 16'd1;
    end
endmodule

// File: rtl/fan_duty_ctrl.sv
// Temperature-to-duty fan controller: hysteretic linear map, slew-limited
// output, start-up kick and fail-safe full duty on stale sensor or override.
module fan_duty_ctrl
    import fan_ctrl_pkg::*;
#(
    parameter logic [11:0] T_LOW         = 12'd2400,
    parameter int          SPAN_LOG2     = 8,
    parameter logic [11:0] HYST          = 12'd32,
    parameter logic [11:0] DUTY_MIN      = 12'd1024,
    parameter logic [11:0] STEP          = 12'd16,
    parameter logic [15:0] TICK_DIV      = 16'd50000,
    parameter logic [7:0]  KICK_TICKS    = 8'd100,
    parameter logic [15:0] TIMEOUT_TICKS = 16'd1000
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    fan_duty_ctrl_if.slave bus
);
    localparam logic [12:0] T_HIGH    = 13'(T_LOW) + 13'(1 << SPAN_LOG2);
    localparam logic [11:0] T_OFF     = (HYST > T_LOW) ? 12'd0 : T_LOW - HYST;
    localparam logic [11:0] DUTY_SPAN = DUTY_FULL - DUTY_MIN;

    logic              tick;
    logic              stale;
    logic [11:0]       target_q, target_d;
    logic              fan_on_q, fan_on_d;
    logic [15:0]       tmo_q;
    logic [7:0]        kick_q;
    logic [11:0]       duty_q;
    fan_state_e        state_q;
    logic [11:0]       ramp_off;
    logic [23:0]       ramp_prod;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .tick_o   (tick)
    );

    // Ramp offset is below 2^SPAN_LOG2 whenever the ramp branch is taken.
    always_comb begin
        ramp_off  = bus.temp_in - T_LOW;
        ramp_prod = 24'(ramp_off) * 24'(DUTY_SPAN);
        target_d  = target_q;
        fan_on_d  = fan_on_q;
        if (bus.temp_valid_in) begin
            if ({1'b0, bus.temp_in} >= T_HIGH) begin
                target_d = DUTY_FULL;
                fan_on_d = 1'b1;
            end else if (bus.temp_in >= T_LOW) begin
                target_d = DUTY_MIN + 12'(ramp_prod >> SPAN_LOG2);
                fan_on_d = 1'b1;
            end else if (bus.temp_in >= T_OFF) begin
                target_d = fan_on_q ? DUTY_MIN : 12'd0;
            end else begin
                target_d = 12'd0;
                fan_on_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            target_q <= DUTY_FULL;
            fan_on_q <= 1'b1;
        end else begin
            target_q <= target_d;
            fan_on_q <= fan_on_d;
        end
    end

    assign stale = (tmo_q >= TIMEOUT_TICKS);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)                             tmo_q <= '0;
        else if (bus.temp_valid_in)                tmo_q <= '0;
        else if (tick && (tmo_q < TIMEOUT_TICKS))  tmo_q <= tmo_q + 16'd1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_KICK;
            duty_q  <= DUTY_FULL;
            kick_q  <= '0;
        end else if (bus.force_full_in || stale) begin
            state_q <= ST_FORCE;
            duty_q  <= DUTY_FULL;
        end else begin
            unique case (state_q)
                ST_FORCE: begin
                    state_q <= fan_on_q ? ST_RUN : ST_OFF;
                    duty_q  <= fan_on_q ? DUTY_FULL : 12'd0;
                end
                ST_OFF: begin
                    if (fan_on_q) begin
                        state_q <= ST_KICK;
                        duty_q  <= DUTY_FULL;
                        kick_q  <= '0;
                    end else begin
                        duty_q  <= 12'd0;
                    end
                end
                ST_KICK: begin
                    if (!fan_on_q) begin
                        state_q <= ST_OFF;
                        duty_q  <= 12'd0;
                    end else begin
                        duty_q <= DUTY_FULL;
                        if (tick) begin
                            kick_q <= kick_q + 8'd1;
                            if (kick_q + 8'd1 == KICK_TICKS) state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!fan_on_q) begin
                        state_q <= ST_OFF;
                        duty_q  <= 12'd0;
                    end else if (tick) begin
                        duty_q  <= slew_toward(duty_q, target_q, STEP);
                    end
                end
            endcase
        end
    end

    assign bus.duty_out      = duty_q;
    assign bus.state_out     = state_q;
    assign bus.at_target_out = (state_q == ST_RUN) && (duty_q == target_q);

endmodule
